snes_joy_port_reader: RTL and testbench
=======================================

Name: snes_joy_port_reader

Overview:
- Console-side controller-port master that drives PORT_LATCH/PORT_CLK to both controller ports.
- Shifts in the serial data lines, presents parallel button words and keeps PORT_LATCH/PORT_CLK at idle levels between reads.
- Also watches the port IO bit (lightgun P6 line) and captures the PPU H/V counters on its falling edge.
- Sits between the CPU auto-joypad/manual-read logic and the external ports.

Parameters:
- HALF_PERIOD, 6: CLK cycles per PORT_CLK half-period, and the unit length of latch. Legal range 4..255.
- LATCH_LEN, 2: PORT_LATCH high time, in half-periods. Minimum 1.
- NBITS, 16: bits shifted per read. Legal range 1..16.

Ports:
- CLK: in, 1. Single system clock.
- RESET_N: in, 1. Asynchronous, active-low reset.
- START: in, 1. Read request pulse.
- BUSY: out, 1. Read in progress.
- DONE: out, 1. One-cycle pulse when a read completes.
- PORT_LATCH: out, 1. Latch to both ports.
- PORT_CLK: out, 1. Serial clock to both ports; idles high.
- P1_DI: in, 2. Port 1 data lines [0]=D0, [1]=D1. Active-low.
- P2_DI: in, 2. Port 2 data lines, same layout. Active-low.
- JOY1, JOY2: out, 16 each. Port 1/2 D0 words, active-high.
- JOY3, JOY4: out, 16 each. Port 1/2 D1 words, active-high.
- IOBIT: in, 1. Port 2 pin 6 (lightgun), asynchronous.
- LG_EN: in, 1. Enable counter capture.
- LG_CLR: in, 1. Clear capture flag.
- HCNT, VCNT: in, 9 each. Live PPU counters.
- OPHCT, OPVCT: out, 9 each. Captured counters.
- LG_FLAG: out, 1. Capture valid.

Behaviour:
- Reset values: PORT_LATCH=0, PORT_CLK=1, BUSY=0, DONE=0, JOY1..4=0, OPHCT=OPVCT=0, LG_FLAG=0, FSM=IDLE, all synchronizer stages=1.
- Reset is asynchronous and may land mid-read: the read is abandoned with no partial update; after release the FSM returns to IDLE.
- Synchronization: P1_DI, P2_DI and IOBIT each pass through a 2-FF synchronizer. Sampling uses the synchronized values only.
- FSM states: IDLE, LATCH, CLK_LO, CLK_HI, FIN.
- IDLE, START=1 (cycle 0): go to LATCH. From cycle 1, PORT_LATCH=1 and BUSY=1.
- START while BUSY=1 is ignored; it is not queued.
- LATCH: lasts LATCH_LEN*HALF_PERIOD cycles, then go to CLK_LO with PORT_LATCH=0.
- CLK_LO: PORT_CLK=0 for HALF_PERIOD cycles. On the last cycle, sample all four synchronized lines, invert them (1=pressed) and shift into four 16-bit temporaries MSB-first.
  - The first bit received lands at bit 15; bit k lands at 15-k.
  - When NBITS<16, the unreceived low bits are 0.
- CLK_HI: PORT_CLK=1 for HALF_PERIOD cycles (the peripheral advances on this rising edge). Then CLK_LO if bits remain, else FIN.
- FIN: one cycle. Copy temporaries to JOY1..4 atomically, DONE=1, BUSY=0, go to IDLE.
- Outputs JOY1..4 change only in FIN.
- START in the cycle after FIN is accepted.
- Timing with defaults: BUSY high for cycles 1..204; PORT_LATCH high for cycles 1..12; PORT_CLK low for cycles 13-18, 25-30, …; DONE at cycle 205.
- Counter capture: a falling edge of synchronized IOBIT with LG_EN=1 and LG_FLAG=0 loads OPHCT<=HCNT, OPVCT<=VCNT and sets LG_FLAG=1.
  - Edges while LG_FLAG=1 or LG_EN=0 are ignored.
  - LG_CLR=1 clears LG_FLAG.
  - LG_CLR in the same cycle as a qualifying edge: the capture happens and LG_FLAG ends at 1.
  - OPHCT/OPVCT hold their value across LG_CLR.
- Capture logic runs independently of the read FSM.

Test Plan:
- Reset, then idle for 50 cycles -> PORT_CLK=1, PORT_LATCH=0, BUSY=0, all outputs 0.
- Port model shifting 16'h7FFF on P1_DI[0] (only the first bit low), START pulse -> DONE at cycle 205, JOY1=16'h8000. JOY2..4=0 while other lines are held 1.
- Lightgun-style model on port 2 returning active-low pattern ~8'b1010_0010 followed by 1s, NBITS=16 -> JOY2=16'hA200. Check latch width is exactly 12 cycles and there are exactly 16 PORT_CLK rising edges.
- START pulses at cycles 50 and 100 during a read -> only one read, one DONE. START in the cycle after DONE -> second read begins next cycle.
- RESET_N low at cycle 80 of a read -> PORT_CLK=1, PORT_LATCH=0 immediately, JOY1..4 keep their reset value 0, no DONE.
- LG_EN=1, IOBIT falls with HCNT=9'd140, VCNT=9'd100 -> after sync delay OPHCT=140, OPVCT=100, LG_FLAG=1. Second fall ignored. LG_CLR coincident with a third fall -> new counters captured, LG_FLAG=1.

Source files
------------

// File: rtl/snes_joy_port_reader.sv
// snes_joy_port_reader: controller-port master that reads both ports serially and captures lightgun counters
module snes_joy_port_reader #(
    parameter int HALF_PERIOD = 6,
    parameter int LATCH_LEN   = 2,
    parameter int NBITS       = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic        PORT_LATCH,
    output logic        PORT_CLK,
    input  logic [1:0]  P1_DI,
    input  logic [1:0]  P2_DI,
    output logic [15:0] JOY1,
    output logic [15:0] JOY2,
    output logic [15:0] JOY3,
    output logic [15:0] JOY4,
    input  logic        IOBIT,
    input  logic        LG_EN,
    input  logic        LG_CLR,
    input  logic [8:0]  HCNT,
    input  logic [8:0]  VCNT,
    output logic [8:0]  OPHCT,
    output logic [8:0]  OPVCT,
    output logic        LG_FLAG
);
    localparam logic [15:0] LAT_END = 16'(LATCH_LEN * HALF_PERIOD - 1);
    localparam logic [15:0] HP_END  = 16'(HALF_PERIOD - 1);
    localparam logic [4:0]  LAST    = 5'(NBITS);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_CLK_LO, S_CLK_HI, S_FIN} state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [4:0]  r_bit;
    logic        r_busy, r_done, r_latch, r_pclk;
    logic [15:0] r_t1, r_t2, r_t3, r_t4;
    logic [15:0] r_j1, r_j2, r_j3, r_j4;
    logic [3:0]  r_d_s1, r_d_s2;
    logic [2:0]  r_io;
    logic [8:0]  r_oph, r_opv;
    logic        r_flag;
    logic [3:0]  w_idx;
    logic        w_fall, w_cap;

    // bit k of a read lands at position 15-k, so short reads leave the low bits clear
    assign w_idx  = 4'(5'd15 - r_bit);
    // the synchronized IOBIT just went low and the capture slot is free (or being freed this cycle)
    assign w_fall = r_io[2] & ~r_io[1];
    assign w_cap  = w_fall & LG_EN & (~r_flag | LG_CLR);

    assign BUSY       = r_busy;
    assign DONE       = r_done;
    assign PORT_LATCH = r_latch;
    assign PORT_CLK   = r_pclk;
    assign JOY1       = r_j1;
    assign JOY2       = r_j2;
    assign JOY3       = r_j3;
    assign JOY4       = r_j4;
    assign OPHCT      = r_oph;
    assign OPVCT      = r_opv;
    assign LG_FLAG    = r_flag;

    // two-stage synchronizer for the four serial data lines {P2 D1, P2 D0, P1 D1, P1 D0}
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_d_s1 <= 4'hF;
            r_d_s2 <= 4'hF;
        end else begin
            r_d_s1 <= {P2_DI, P1_DI};
            r_d_s2 <= r_d_s1;
        end
    end

    // read sequencer: latch pulse, then NBITS clock periods sampling at the end of each low phase
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_latch <= 1'b0;
            r_pclk  <= 1'b1;
            r_t1    <= '0;
            r_t2    <= '0;
            r_t3    <= '0;
            r_t4    <= '0;
            r_j1    <= '0;
            r_j2    <= '0;
            r_j3    <= '0;
            r_j4    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_state <= S_LATCH;
                        r_latch <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_t1    <= '0;
                        r_t2    <= '0;
                        r_t3    <= '0;
                        r_t4    <= '0;
                    end
                end
                S_LATCH: begin
                    if (r_cnt == LAT_END) begin
                        r_state <= S_CLK_LO;
                        r_latch <= 1'b0;
                        r_pclk  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_CLK_LO: begin
                    if (r_cnt == HP_END) begin
                        r_t1[w_idx] <= ~r_d_s2[0];
                        r_t2[w_idx] <= ~r_d_s2[2];
                        r_t3[w_idx] <= ~r_d_s2[1];
                        r_t4[w_idx] <= ~r_d_s2[3];
                        r_bit       <= r_bit + 5'd1;
                        r_pclk      <= 1'b1;
                        r_state     <= S_CLK_HI;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_CLK_HI: begin
                    if (r_cnt == HP_END) begin
                        r_cnt <= '0;
                        if (r_bit == LAST) begin
                            r_state <= S_FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_j1    <= r_t1;
                            r_j2    <= r_t2;
                            r_j3    <= r_t3;
                            r_j4    <= r_t4;
                        end else begin
                            r_state <= S_CLK_LO;
                            r_pclk  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // IOBIT synchronizer plus edge history, and counter capture on a qualifying falling edge
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_io   <= 3'b111;
            r_oph  <= '0;
            r_opv  <= '0;
            r_flag <= 1'b0;
        end else begin
            r_io <= {r_io[1:0], IOBIT};
            if (w_cap) begin
                r_oph  <= HCNT;
                r_opv  <= VCNT;
                r_flag <= 1'b1;
            end else if (LG_CLR) begin
                r_flag <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_snes_joy_port_reader.sv
// tb_snes_joy_port_reader: directed checks of port reads, restart/abort handling and lightgun capture
module tb_snes_joy_port_reader;
    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        START = 1'b0;
    logic        BUSY, DONE, PORT_LATCH, PORT_CLK;
    logic [1:0]  P1_DI, P2_DI;
    logic [15:0] JOY1, JOY2, JOY3, JOY4;
    logic        IOBIT = 1'b1;
    logic        LG_EN = 1'b0;
    logic        LG_CLR = 1'b0;
    logic [8:0]  HCNT = '0;
    logic [8:0]  VCNT = '0;
    logic [8:0]  OPHCT, OPVCT;
    logic        LG_FLAG;

    int n_pass = 0;
    int n_chk  = 0;

    // peripheral model: patterns are the raw active-low serial streams, first bit in [15]
    logic [15:0] pat0 = 16'hFFFF, pat1 = 16'hFFFF, pat2 = 16'hFFFF, pat3 = 16'hFFFF;
    logic [15:0] sr0 = 16'hFFFF, sr1 = 16'hFFFF, sr2 = 16'hFFFF, sr3 = 16'hFFFF;

    // results gathered by run_read
    int   n_latch, latch_last, n_rise, n_done, done_cyc, busy_first, busy_last;
    logic pc13, pc18, pc19, busy206, busy207, latch207;
    logic ab_clk, ab_latch, ab_busy, ab_done;

    snes_joy_port_reader dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .BUSY(BUSY), .DONE(DONE),
        .PORT_LATCH(PORT_LATCH), .PORT_CLK(PORT_CLK), .P1_DI(P1_DI), .P2_DI(P2_DI),
        .JOY1(JOY1), .JOY2(JOY2), .JOY3(JOY3), .JOY4(JOY4),
        .IOBIT(IOBIT), .LG_EN(LG_EN), .LG_CLR(LG_CLR), .HCNT(HCNT), .VCNT(VCNT),
        .OPHCT(OPHCT), .OPVCT(OPVCT), .LG_FLAG(LG_FLAG)
    );

    always #5 CLK = ~CLK;

    assign P1_DI = {sr1[15], sr0[15]};
    assign P2_DI = {sr3[15], sr2[15]};

    // shift registers load on latch and advance on each PORT_CLK rising edge, filling with 1s
    always @(posedge PORT_LATCH or posedge PORT_CLK) begin
        if (PORT_LATCH) begin
            sr0 <= pat0; sr1 <= pat1; sr2 <= pat2; sr3 <= pat3;
        end else begin
            sr0 <= {sr0[14:0], 1'b1}; sr1 <= {sr1[14:0], 1'b1};
            sr2 <= {sr2[14:0], 1'b1}; sr3 <= {sr3[14:0], 1'b1};
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        RESET_N = 1'b0;
        START = 1'b0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
    endtask

    // issues START (cycle 0) and monitors cycles 1..max_cyc; extra adds STARTs at 50, 100 and 206
    task automatic run_read(input bit extra, input int abort_at, input int max_cyc);
        logic prev;
        n_latch = 0; latch_last = 0; n_rise = 0; n_done = 0; done_cyc = 0;
        busy_first = 0; busy_last = 0;
        START = 1'b1;
        @(posedge CLK); #1;
        prev = PORT_CLK;
        for (int c = 1; c <= max_cyc; c++) begin
            if (PORT_LATCH) begin n_latch++; latch_last = c; end
            if (PORT_CLK && !prev) n_rise++;
            prev = PORT_CLK;
            if (DONE) begin n_done++; done_cyc = c; end
            if (BUSY && busy_first == 0) busy_first = c;
            if (BUSY) busy_last = c;
            if (c == 13) pc13 = PORT_CLK;
            if (c == 18) pc18 = PORT_CLK;
            if (c == 19) pc19 = PORT_CLK;
            if (c == 206) busy206 = BUSY;
            if (c == 207) begin busy207 = BUSY; latch207 = PORT_LATCH; end
            START = extra && (c == 50 || c == 100 || c == 206);
            if (c == abort_at) begin
                RESET_N = 1'b0;
                #1;
                ab_clk = PORT_CLK; ab_latch = PORT_LATCH; ab_busy = BUSY; ab_done = DONE;
            end
            if (abort_at > 0 && c == abort_at + 5) RESET_N = 1'b1;
            @(posedge CLK); #1;
        end
        START = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (50) @(negedge CLK);
        n_chk++; if (PORT_CLK !== 1'b1) $display("FAIL reset_port_clk: got %b want 1", PORT_CLK); else n_pass++;
        n_chk++; if (PORT_LATCH !== 1'b0) $display("FAIL reset_port_latch: got %b want 0", PORT_LATCH); else n_pass++;
        n_chk++; if ({BUSY, DONE} !== 2'b00) $display("FAIL reset_busy_done: got %b want 00", {BUSY, DONE}); else n_pass++;
        n_chk++; if ({JOY1, JOY2, JOY3, JOY4} !== 64'h0) $display("FAIL reset_joy: got %h want 0", {JOY1, JOY2, JOY3, JOY4}); else n_pass++;
        n_chk++; if ({OPHCT, OPVCT, LG_FLAG} !== 19'h0) $display("FAIL reset_lg: got %h want 0", {OPHCT, OPVCT, LG_FLAG}); else n_pass++;
    endtask

    task automatic test_read_p1();
        pat0 = 16'h7FFF; pat1 = 16'hFFFF; pat2 = 16'hFFFF; pat3 = 16'hFFFF;
        run_read(1'b0, 0, 210);
        n_chk++; if (done_cyc != 205) $display("FAIL p1_done_cycle: got %0d want 205", done_cyc); else n_pass++;
        n_chk++; if (n_done != 1) $display("FAIL p1_done_count: got %0d want 1", n_done); else n_pass++;
        n_chk++; if (busy_first != 1 || busy_last != 204) $display("FAIL p1_busy_window: got %0d..%0d want 1..204", busy_first, busy_last); else n_pass++;
        n_chk++; if (n_latch != 12 || latch_last != 12) $display("FAIL p1_latch: got %0d cycles ending %0d want 12 ending 12", n_latch, latch_last); else n_pass++;
        n_chk++; if ({pc13, pc18, pc19} !== 3'b001) $display("FAIL p1_clk_phase: got %b want 001", {pc13, pc18, pc19}); else n_pass++;
        n_chk++; if (JOY1 !== 16'h8000) $display("FAIL p1_joy1: got %h want 8000", JOY1); else n_pass++;
        n_chk++; if ({JOY2, JOY3, JOY4} !== 48'h0) $display("FAIL p1_joy234: got %h want 0", {JOY2, JOY3, JOY4}); else n_pass++;
    endtask

    task automatic test_read_p2();
        pat0 = 16'hFFFF; pat1 = 16'h3C0F; pat2 = 16'h5DFF; pat3 = 16'hFFFF;
        run_read(1'b0, 0, 210);
        n_chk++; if (JOY2 !== 16'hA200) $display("FAIL p2_joy2: got %h want a200", JOY2); else n_pass++;
        n_chk++; if (JOY3 !== 16'hC3F0) $display("FAIL p2_joy3: got %h want c3f0", JOY3); else n_pass++;
        n_chk++; if ({JOY1, JOY4} !== 32'h0) $display("FAIL p2_joy14: got %h want 0", {JOY1, JOY4}); else n_pass++;
        n_chk++; if (n_latch != 12) $display("FAIL p2_latch_width: got %0d want 12", n_latch); else n_pass++;
        n_chk++; if (n_rise != 16) $display("FAIL p2_clk_rises: got %0d want 16", n_rise); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit got;
        pat0 = 16'hFFFF; pat1 = 16'hFFFF; pat2 = 16'hFFFF; pat3 = 16'hFFFF;
        run_read(1'b1, 0, 207);
        n_chk++; if (n_done != 1 || done_cyc != 205) $display("FAIL b2b_single_done: got %0d at %0d want 1 at 205", n_done, done_cyc); else n_pass++;
        n_chk++; if (busy206 !== 1'b0) $display("FAIL b2b_idle_gap: got busy %b want 0", busy206); else n_pass++;
        n_chk++; if ({busy207, latch207} !== 2'b11) $display("FAIL b2b_restart: got %b want 11", {busy207, latch207}); else n_pass++;
        got = 1'b0;
        repeat (250) begin
            @(posedge CLK); #1;
            if (DONE) got = 1'b1;
        end
        n_chk++; if (!got) $display("FAIL b2b_second_done: got none want 1"); else n_pass++;
    endtask

    task automatic test_abort();
        pat0 = 16'h0000; pat1 = 16'h0000; pat2 = 16'h0000; pat3 = 16'h0000;
        run_read(1'b0, 80, 260);
        n_chk++; if ({ab_clk, ab_latch, ab_busy, ab_done} !== 4'b1000) $display("FAIL abort_outputs: got %b want 1000", {ab_clk, ab_latch, ab_busy, ab_done}); else n_pass++;
        n_chk++; if (n_done != 0) $display("FAIL abort_no_done: got %0d want 0", n_done); else n_pass++;
        n_chk++; if ({JOY1, JOY2, JOY3, JOY4} !== 64'h0) $display("FAIL abort_joy: got %h want 0", {JOY1, JOY2, JOY3, JOY4}); else n_pass++;
        n_chk++; if ({BUSY, PORT_CLK, PORT_LATCH} !== 3'b010) $display("FAIL abort_idle: got %b want 010", {BUSY, PORT_CLK, PORT_LATCH}); else n_pass++;
    endtask

    task automatic test_lightgun();
        @(negedge CLK);
        LG_EN = 1'b1; HCNT = 9'd140; VCNT = 9'd100; IOBIT = 1'b0;
        repeat (5) @(negedge CLK);
        n_chk++; if ({OPHCT, OPVCT, LG_FLAG} !== {9'd140, 9'd100, 1'b1}) $display("FAIL lg_first: got %0d/%0d/%b want 140/100/1", OPHCT, OPVCT, LG_FLAG); else n_pass++;
        HCNT = 9'd200; VCNT = 9'd50; IOBIT = 1'b1;
        repeat (5) @(negedge CLK);
        IOBIT = 1'b0;
        repeat (5) @(negedge CLK);
        n_chk++; if ({OPHCT, OPVCT, LG_FLAG} !== {9'd140, 9'd100, 1'b1}) $display("FAIL lg_second_ignored: got %0d/%0d/%b want 140/100/1", OPHCT, OPVCT, LG_FLAG); else n_pass++;
        IOBIT = 1'b1;
        repeat (5) @(negedge CLK);
        HCNT = 9'd311; VCNT = 9'd222; IOBIT = 1'b0;
        repeat (2) @(negedge CLK);
        LG_CLR = 1'b1;
        @(negedge CLK);
        LG_CLR = 1'b0;
        repeat (2) @(negedge CLK);
        n_chk++; if ({OPHCT, OPVCT, LG_FLAG} !== {9'd311, 9'd222, 1'b1}) $display("FAIL lg_clr_coincident: got %0d/%0d/%b want 311/222/1", OPHCT, OPVCT, LG_FLAG); else n_pass++;
        LG_CLR = 1'b1;
        @(negedge CLK);
        LG_CLR = 1'b0;
        @(negedge CLK);
        n_chk++; if ({OPHCT, OPVCT, LG_FLAG} !== {9'd311, 9'd222, 1'b0}) $display("FAIL lg_clr_hold: got %0d/%0d/%b want 311/222/0", OPHCT, OPVCT, LG_FLAG); else n_pass++;
        LG_EN = 1'b0; HCNT = 9'd7; VCNT = 9'd8; IOBIT = 1'b1;
        repeat (5) @(negedge CLK);
        IOBIT = 1'b0;
        repeat (5) @(negedge CLK);
        n_chk++; if ({OPHCT, OPVCT, LG_FLAG} !== {9'd311, 9'd222, 1'b0}) $display("FAIL lg_disabled: got %0d/%0d/%b want 311/222/0", OPHCT, OPVCT, LG_FLAG); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_read_p1();
        test_read_p2();
        test_back_to_back();
        do_reset();
        test_abort();
        test_lightgun();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
